// File: rtl/be_word_serializer_pkg.sv
// be_word_serializer shared types and sizing.
// BESER_PARITY_EN adds a registered even-parity output lane.
package be_word_serializer_pkg;

  localparam int BESER_WIDTH = 8;
  localparam int BESER_WORD  = 4;
  localparam int BESER_FULLW = BESER_WIDTH * BESER_WORD;
  localparam int BESER_LEN_W = $clog2(BESER_WORD) + 1;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

endpackage

// File: rtl/be_len_clamp.sv
// be_len_clamp: maps a requested byte count onto 1..WORD.
// Shared by the serializer and the deserializer.
module be_len_clamp
  import be_word_serializer_pkg::*;
#(
  parameter int WORD = BESER_WORD,
  parameter int CNTW = $clog2(WORD) + 1
) (
  input  logic [CNTW-1:0] len,
  output logic [CNTW-1:0] clamped
);

  always_comb begin
    clamped = len;
    if (len == '0 || len > CNTW'(WORD))
      clamped = CNTW'(WORD);
  end

endmodule

// File: rtl/be_word_serializer.sv
// be_word_serializer: word in, MSB-first byte stream out.
// Optional BESER_PARITY_EN adds out_par (XOR of out_data).
module be_word_serializer
  import be_word_serializer_pkg::*;
#(
  parameter int WIDTH = BESER_WIDTH,
  parameter int WORD  = BESER_WORD,
  parameter int FULLW = WIDTH * WORD,
  parameter int CNTW  = $clog2(WORD) + 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [FULLW-1:0] in_data,
  input  logic [CNTW-1:0]  in_len,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy
`ifdef BESER_PARITY_EN
  , output logic           out_par
`endif
);

  state_t           state, state_n;
  logic [FULLW-1:0] sr, sr_n, sr_sh;
  logic [CNTW-1:0]  len, len_n;
  logic [CNTW-1:0]  idx, idx_n;
  logic [CNTW-1:0]  len_c;
  logic [WIDTH-1:0] data_q, data_n;
  logic             last_q, last_n;
  logic             xfer, take;

  be_len_clamp #(
    .WORD (WORD),
    .CNTW (CNTW)
  ) u_clamp (
    .len     (in_len),
    .clamped (len_c)
  );

  assign out_valid = (state == ST_SEND);
  assign busy      = out_valid;
  assign out_data  = data_q;
  assign out_last  = last_q;
  assign xfer      = out_valid && out_ready;
  assign in_ready  = (state == ST_IDLE) || (xfer && last_q);
  assign take      = in_valid && in_ready;
  assign sr_sh     = sr << WIDTH;

  always_comb begin
    state_n = state;
    sr_n    = sr;
    len_n   = len;
    idx_n   = idx;
    data_n  = data_q;
    last_n  = last_q;
    if (take) begin
      // covers both IDLE accept and zero-bubble reload on last byte
      state_n = ST_SEND;
      sr_n    = in_data;
      len_n   = len_c;
      idx_n   = '0;
      data_n  = in_data[FULLW-1 -: WIDTH];
      last_n  = (len_c == CNTW'(1));
    end else if (xfer && last_q) begin
      state_n = ST_IDLE;
      idx_n   = '0;
      data_n  = '0;
      last_n  = 1'b0;
    end else if (xfer) begin
      sr_n   = sr_sh;
      idx_n  = idx + CNTW'(1);
      data_n = sr_sh[FULLW-1 -: WIDTH];
      last_n = ((idx + CNTW'(1)) == (len - CNTW'(1)));
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= ST_IDLE;
      sr     <= '0;
      len    <= '0;
      idx    <= '0;
      data_q <= '0;
      last_q <= 1'b0;
    end else begin
      state  <= state_n;
      sr     <= sr_n;
      len    <= len_n;
      idx    <= idx_n;
      data_q <= data_n;
      last_q <= last_n;
    end
  end

`ifdef BESER_PARITY_EN
  logic par_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      par_q <= 1'b0;
    else
      par_q <= ^data_n;
  end

  assign out_par = par_q;
`endif

endmodule

// File: doc/be_word_serializer.md
Name: be_word_serializer

Overview:
- Converts a full-width word into a stream of WIDTH-bit bytes, most-significant byte first.
- This is the read-out direction of the big-endian byte-lane register. Byte index 0 is the MSB lane, d[FULLW-1 -: WIDTH].
- Sits between the CPU datapath and byte-wide sinks such as the UART TX and the byte-addressed store path.
- Accepts one word per valid/ready handshake and emits 1..WORD bytes per word on a second valid/ready handshake.

Parameters:
- WIDTH, default 8 (`WIDTH): bits per byte lane.
- WORD, default 4 (`WORD): byte lanes per word.
- FULLW, default WIDTH*WORD (`FULLW): word width.
- CNTW, default $clog2(WORD)+1: byte counter and length width.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  word offered.
- in_ready  out  1  block can accept a word this cycle.
- in_data  in  FULLW  word, big-endian lane order.
- in_len  in  CNTW  number of bytes to emit, 1..WORD, taken MSB-first. 0 or any value >WORD is treated as WORD.
- out_valid  out  1  out_data holds a byte.
- out_ready  in  1  sink accepts the byte.
- out_data  out  WIDTH  current byte.
- out_last  out  1  current byte is the final byte of the word.
- busy  out  1  a word is in flight (out_valid high).

Behaviour:
- Reset (async assert, sync release): state=IDLE; out_valid=0, out_data=0, out_last=0, busy=0, internal counter=0. in_ready is 1 once reset_n is high.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1.
  - On in_valid: latch in_data into shift register sr; latch clamped length into len; set idx=0; go to SEND.
  - First byte is presented the next cycle (1-cycle latency): out_valid=1, out_data=sr[FULLW-1 -: WIDTH], out_last=(len==1).
- SEND:
  - out_valid=1. out_data, out_last and busy are registered outputs.
  - Byte transfers when out_valid && out_ready.
  - On a transfer with idx<len-1: sr shifts left by WIDTH; idx++; out_last=(idx+1==len-1).
  - On a transfer of the last byte: if in_valid, the next word is latched in the same cycle and SEND continues with zero bubble (in_ready=1 in this cycle only). Otherwise go to IDLE with out_valid=0.
- in_ready = (state==IDLE) || (out_valid && out_ready && out_last). Combinational from out_ready, and only for that term.
- out_ready low: out_data, out_last and out_valid are held stable (AXI-style; the block never retracts or changes a byte).
- in_len truncation: only the top len bytes are emitted; the lower lanes are discarded.
- reset_n asserted mid-word: the word is dropped. No partial-word state survives.
- Counter idx is never compared at WORD; len≤WORD guarantees no wrap.

Optional Feature:
- Macro BESER_PARITY_EN.
- When defined: adds output port out_par (1 bit). out_par is the even parity (XOR reduction) of out_data, registered and aligned with out_data. It resets to 0 and is held under stall like out_data.
- When undefined: the port and its logic are absent, and behaviour is otherwise identical.

Decomposition:
- Shared package/defines (defines.v): WIDTH, WORD, FULLW. Add BESER_LEN_W = $clog2(`WORD)+1 and the state encoding constants ST_IDLE=1'b0, ST_SEND=1'b1.
- One natural sub-module: be_len_clamp. It is combinational: maps in_len to 1..WORD and is reused by the future deserializer.
- Everything else stays in one module.

Test Plan:
- Reset with in_valid=1 → out_valid=0, in_ready=1 during reset; no byte emitted until after release.
- in_data=32'hDEADBEEF, in_len=4, out_ready=1 → bytes DE,AD,BE,EF on 4 consecutive cycles starting 1 cycle after accept; out_last only on EF; then IDLE.
- Same word, out_ready toggling 1,0,0,1,… → each byte held stable while stalled; order DE,AD,BE,EF; no duplicates or drops.
- Back-to-back words 32'h01020304 (len 4) then 32'hA0B0C0D0 (len 2) with in_valid held → 01,02,03,04,A0,B0 with no bubble; in_ready pulses only on the 04 transfer; C0/D0 never appear.
- in_len=0 and in_len=7 with 32'h11223344 → both emit 4 bytes, 11..44.
- reset_n pulsed low after 2 of 4 bytes → out_valid drops asynchronously; next word starts from its MSB. With BESER_PARITY_EN: byte 8'h07 → out_par=1, byte 8'h03 → out_par=0.
